// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the inst/data RAM port arbiter.
// Holds FSM states, owner codes and the byte-merge function.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [3:0] WSTRB_FULL = 4'hF;

  // First state after a grant; partial stores must read the old word first
  function automatic state_e first_state(
    input logic       wr,
    input logic [3:0] strb
  );
    state_e s;
    if (!wr) begin
      s = RD;
    end else if (strb == WSTRB_FULL) begin
      s = WR;
    end else if (strb == 4'h0) begin
      s = RESP;
    end else begin
      s = RD;
    end
    return s;
  endfunction

  function automatic logic [31:0] merge_word(
    input logic [31:0] old,
    input logic [31:0] wdata,
    input logic [3:0]  strb
  );
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// CPU-side inst/data handshakes plus the shared RAM port.
// slave = arbiter view, master = core/RAM environment view.
interface ram_arb_if #(
  parameter int ADDR_WIDTH = 15
);

  logic                  inst_req;
  logic [31:0]           inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [31:0]           inst_rdata;

  logic                  data_req;
  logic                  data_wr;
  logic [3:0]            data_wstrb;
  logic [31:0]           data_addr;
  logic [31:0]           data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [31:0]           data_rdata;

  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_we;
  logic [31:0]           ram_d;
  logic [31:0]           ram_spo;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_wstrb,
    input  data_addr, data_wdata,
    input  ram_spo,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output ram_a, ram_we, ram_d
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_wstrb,
    output data_addr, data_wdata,
    output ram_spo,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  ram_a, ram_we, ram_d
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = inst, bit 1 = data.
// On conflict the port not granted last time wins.
module ram_rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (&req) begin
        grant = (last == OWNER_DATA) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one async-read word RAM between fetch and load/store ports.
// Round-robin grant, one outstanding access, RMW for partial stores.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input logic      clk,
  input logic      reset,
  ram_arb_if.slave bus
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;

  logic [1:0]            req;
  logic [1:0]            grant;
  logic                  arb_en;
  logic                  we;
  logic                  inst_ok;
  logic                  data_ok;
  logic [31:0]           inst_rd;
  logic [31:0]           data_rd;
  logic                  unused_addr_bits;

  assign req    = {bus.data_req, bus.inst_req};
  assign arb_en = (state_q == IDLE) && !reset;

  ram_rr_arb2 u_arb (
    .req   (req),
    .last  (last_q),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    we      = 1'b0;
    inst_ok = 1'b0;
    data_ok = 1'b0;
    inst_rd = '0;
    data_rd = '0;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          owner_d = grant[OWNER_DATA] ? OWNER_DATA : OWNER_INST;
          last_d  = owner_d;
          if (grant[OWNER_DATA]) begin
            addr_d  = bus.data_addr[ADDR_WIDTH+1:2];
            wr_d    = bus.data_wr;
            wstrb_d = bus.data_wstrb;
            wdata_d = bus.data_wdata;
          end else begin
            addr_d  = bus.inst_addr[ADDR_WIDTH+1:2];
            wr_d    = 1'b0;
            wstrb_d = '0;
            wdata_d = '0;
          end
          state_d = first_state(wr_d, wstrb_d);
        end
      end
      RD: begin
        buf_d   = bus.ram_spo;
        state_d = wr_q ? WR : RESP;
      end
      WR: begin
        we      = !reset;
        state_d = RESP;
      end
      RESP: begin
        inst_ok = !reset && (owner_q == OWNER_INST);
        data_ok = !reset && (owner_q == OWNER_DATA);
        inst_rd = inst_ok ? buf_q : '0;
        data_rd = (data_ok && !wr_q) ? buf_q : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWNER_INST;
      last_q  <= OWNER_INST;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.inst_addr_ok = grant[OWNER_INST];
  assign bus.data_addr_ok = grant[OWNER_DATA];
  assign bus.inst_data_ok = inst_ok;
  assign bus.data_data_ok = data_ok;
  assign bus.inst_rdata   = inst_rd;
  assign bus.data_rdata   = data_rd;
  assign bus.ram_a        = addr_q;
  assign bus.ram_we       = we;
  // Full strobe selects every wdata byte, so one merge covers both store kinds
  assign bus.ram_d        = merge_word(buf_q, wdata_q, wstrb_q);

  assign unused_addr_bits = ^{bus.inst_addr[31:ADDR_WIDTH+2],
                              bus.inst_addr[1:0],
                              bus.data_addr[31:ADDR_WIDTH+2],
                              bus.data_addr[1:0]};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: RAM model, reference memory and
// arbitration model, directed plan plus randomized transactions.
module tb_ram_port_arbiter;

  localparam int AW = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_arb_if #(.ADDR_WIDTH(AW)) bus ();

  ram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  assign bus.ram_spo = mem[bus.ram_a];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_a] = bus.ram_d;

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          last_data;
  logic [31:0] cur_addr [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] old,
      input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] m;
    m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
    return (wd & m) | (old & ~m);
  endfunction

  function automatic int ref_latency(input bit wr, input logic [3:0] st);
    if (!wr) return 2;
    if (st == 4'hF) return 2;
    if (st == 4'h0) return 1;
    return 3;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    r[AW+1:2] = 15'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic logic dok(input bit p);
    return p ? bus.data_data_ok : bus.inst_data_ok;
  endfunction

  function automatic logic [31:0] rdat(input bit p);
    return p ? bus.data_rdata : bus.inst_rdata;
  endfunction

  task automatic drive(input bit p, input bit wr, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      bus.data_req   = 1'b1;
      bus.data_wr    = wr;
      bus.data_wstrb = st;
      bus.data_addr  = a;
      bus.data_wdata = wd;
    end else begin
      bus.inst_req  = 1'b1;
      bus.inst_addr = a;
    end
  endtask

  task automatic accept(input bit p, input string tag, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      got = bus.inst_addr_ok | bus.data_addr_ok;
    end
    chk({tag, "_grant"}, {bus.data_addr_ok, bus.inst_addr_ok},
        p ? 32'd2 : 32'd1);
  endtask

  task automatic follow(input bit p, input bit wr, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] wd,
                        input string tag, input bit hold);
    int          w;
    int          n;
    int          we_n;
    bit          seen;
    bit          stray;
    logic [31:0] exp_rd;
    w      = int'(a[AW+1:2]);
    exp_rd = wr ? 32'h0 : ref_mem[w];
    if (wr) ref_mem[w] = ref_merge(ref_mem[w], wd, st);
    last_data = p;
    n = 0; we_n = 0; seen = 0; stray = 0;
    @(posedge clk);
    #1;
    if (!hold) begin
      if (p) bus.data_req = 1'b0;
      else bus.inst_req = 1'b0;
    end else begin
      cur_addr[p] = rand_addr();
      drive(p, 1'b0, 4'h0, cur_addr[p], 32'h0);
    end
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.ram_we) we_n++;
      if (bus.inst_addr_ok || bus.data_addr_ok) stray = 1'b1;
      if (dok(!p)) stray = 1'b1;
      if (dok(p)) seen = 1'b1;
    end
    chk({tag, "_latency"}, n, ref_latency(wr, st));
    chk({tag, "_rdata"}, rdat(p), exp_rd);
    chk({tag, "_we_cycles"}, we_n, (wr && st != 4'h0) ? 1 : 0);
    chk({tag, "_exclusive"}, stray, 0);
    chk({tag, "_ram_word"}, mem[w], ref_mem[w]);
  endtask

  task automatic txn(input bit p, input bit wr, input logic [3:0] st,
                     input logic [31:0] a, input logic [31:0] wd,
                     input string tag);
    int n;
    drive(p, wr, st, a, wd);
    accept(p, tag, n);
    follow(p, wr, st, a, wd, tag, 1'b0);
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h0;
    bus.data_req   = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_wstrb = 4'hF;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = i * 32'h9E3779B1;
      ref_mem[i] = mem[i];
    end
    mem[16]     = 32'hA1B2C3D4;
    ref_mem[16] = 32'hA1B2C3D4;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", {bus.data_addr_ok, bus.inst_addr_ok}, 0);
    chk("rst_data_ok", {bus.data_data_ok, bus.inst_data_ok}, 0);
    chk("rst_ram_we", bus.ram_we, 0);
    chk("rst_inst_rdata", bus.inst_rdata, 0);
    chk("rst_data_rdata", bus.data_rdata, 0);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    last_data    = 1'b0;

    txn(1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, "plan_fetch");
    chk("plan_fetch_value", bus.inst_rdata, 32'hA1B2C3D4);
    txn(1'b1, 1'b1, 4'b0101, 32'h0000_0040, 32'h11223344, "plan_pstore");
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, "plan_pload");
    chk("plan_merge_value", bus.data_rdata, 32'hA122C344);
    txn(1'b1, 1'b1, 4'hF, 32'h0000_0080, 32'hDEADBEEF, "plan_fstore");
    txn(1'b1, 1'b1, 4'h0, 32'h0000_0080, 32'h12345678, "plan_zstore");
    txn(1'b1, 1'b0, 4'h0, 32'h0000_0080, 32'h0, "plan_fload");
    chk("plan_full_value", bus.data_rdata, 32'hDEADBEEF);

    drive(1'b1, 1'b1, 4'b0110, 32'h0000_00C0, 32'hCAFEF00D);
    accept(1'b1, "rstwr", n);
    @(posedge clk);
    #1 bus.data_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rstwr_ram_we", bus.ram_we, 0);
    chk("rstwr_data_ok", {bus.data_data_ok, bus.inst_data_ok}, 0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    last_data = 1'b0;
    chk("rstwr_word", mem[48], ref_mem[48]);

    cur_addr[0] = rand_addr();
    cur_addr[1] = rand_addr();
    drive(1'b0, 1'b0, 4'h0, cur_addr[0], 32'h0);
    drive(1'b1, 1'b0, 4'h0, cur_addr[1], 32'h0);
    for (int k = 0; k < 6; k++) begin
      bit e;
      e = !last_data;
      accept(e, $sformatf("rr%0d", k), n);
      if (k == 0) chk("rr_first_cycle", n, 1);
      follow(e, 1'b0, 4'h0, cur_addr[e], 32'h0, $sformatf("rr%0d", k), 1'b1);
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;

    for (int k = 0; k < 24; k++) begin
      bit          p;
      bit          wr;
      logic [3:0]  st;
      logic [31:0] wd;
      p  = 1'($urandom_range(0, 1));
      wr = p ? 1'($urandom_range(0, 1)) : 1'b0;
      st = 4'($urandom_range(0, 15));
      wd = $urandom;
      txn(p, wr, st, rand_addr(), wd, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
